// File: rtl/mix_pkg.sv
// rtl/mix_pkg.sv - shared MIX word geometry, opcode/register constants and load FSM states
package mix_pkg;
    localparam int WW       = 31;
    localparam int AW       = 12;
    localparam int BYTE_W   = 6;
    localparam int NBYTES   = 5;
    localparam int SIGN_BIT = 30;

    localparam logic [5:0] OP_LDA  = 6'd8;
    localparam logic [5:0] OP_LDX  = 6'd15;
    localparam logic [5:0] OP_LDAN = 6'd16;
    localparam logic [5:0] OP_LDXN = 6'd23;

    localparam logic [2:0] REG_A = 3'd0;
    localparam logic [2:0] REG_X = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_EXEC = 2'd2
    } ld_state_t;
endpackage

// File: rtl/ld_field_extract.sv
// rtl/ld_field_extract.sv - extracts partial field (L:R) of a word, right-justified
module ld_field_extract
    import mix_pkg::*;
(
    input  logic [WW-1:0] data,
    input  logic [2:0]    l,
    input  logic [2:0]    r,
    output logic [WW-2:0] magnitude,
    output logic          sign_keep,
    output logic          valid
);
    int lo_i;
    int r_i;
    int sh;

    always_comb begin
        magnitude = '0;
        lo_i      = (l == 3'd0) ? 1 : int'(l);
        r_i       = int'(r);
        valid     = (l <= r) && (r <= 3'd5);
        sign_keep = (l == 3'd0);
        // Byte k sits at bit (5-k)*6; shifting by (5-R) bytes right-justifies byte R.
        sh        = (NBYTES - r_i) * BYTE_W;
        for (int k = 1; k <= NBYTES; k++) begin
            if (valid && k >= lo_i && k <= r_i)
                magnitude[(NBYTES - k) * BYTE_W - sh +: BYTE_W] = data[(NBYTES - k) * BYTE_W +: BYTE_W];
        end
    end
endmodule

// File: rtl/ld_unit.sv
// rtl/ld_unit.sv - MIX load unit (LDA..LDX, LDAN..LDXN): read word, extract field, write register
module ld_unit
    import mix_pkg::*;
#(
    parameter int AW = mix_pkg::AW,
    parameter int WW = mix_pkg::WW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [5:0]    opcode,
    input  logic [5:0]    field,
    input  logic [AW-1:0] addressin,
    output logic [AW-1:0] addressout,
    input  logic [WW-1:0] data,
    output logic [WW-1:0] out,
    output logic [2:0]    regsel,
    output logic          we,
    output logic          stop,
    output logic          bad_field,
    output logic          idx_ovf
);
    ld_state_t     state;
    logic [5:0]    op_q;
    logic [5:0]    field_q;
    logic [WW-2:0] mag;
    logic          sign_keep;
    logic          fld_ok;
    logic          op_ok;
    logic          negate;
    logic [2:0]    rsel;
    logic          bad;
    logic          idx;
    logic          sign;

    ld_field_extract u_extract (
        .data      (data),
        .l         (field_q[5:3]),
        .r         (field_q[2:0]),
        .magnitude (mag),
        .sign_keep (sign_keep),
        .valid     (fld_ok)
    );

    assign op_ok  = (op_q >= OP_LDA) && (op_q <= OP_LDXN);
    assign negate = (op_q >= OP_LDAN);
    // (opcode - 8) mod 8 is just the low three opcode bits.
    assign rsel   = op_q[2:0];
    assign bad    = !(fld_ok && op_ok);
    assign sign   = (sign_keep & data[WW-1]) ^ negate;
    assign idx    = (rsel != REG_A) && (rsel != REG_X) && (|mag[WW-2:WW-19]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            addressout <= '0;
            op_q       <= '0;
            field_q    <= '0;
            out        <= '0;
            regsel     <= '0;
            we         <= 1'b0;
            stop       <= 1'b0;
            bad_field  <= 1'b0;
            idx_ovf    <= 1'b0;
        end else begin
            we   <= 1'b0;
            stop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addressout <= addressin;
                        op_q       <= opcode;
                        field_q    <= field;
                        state      <= ST_ADDR;
                    end
                end
                ST_ADDR: state <= ST_EXEC;
                ST_EXEC: begin
                    stop      <= 1'b1;
                    regsel    <= rsel;
                    bad_field <= bad;
                    idx_ovf   <= idx & ~bad;
                    if (!bad) begin
                        out <= {sign, mag};
                        we  <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ld_unit.sv
// tb/tb_ld_unit.sv - directed self-checking bench for ld_unit
module tb_ld_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  opcode;
    logic [5:0]  field;
    logic [11:0] addressin;
    logic [11:0] addressout;
    logic [30:0] data;
    logic [30:0] out;
    logic [2:0]  regsel;
    logic        we;
    logic        stop;
    logic        bad_field;
    logic        idx_ovf;

    logic [30:0] mem [0:4095];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) data <= mem[addressout];

    ld_unit dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .field(field),
        .addressin(addressin), .addressout(addressout), .data(data), .out(out),
        .regsel(regsel), .we(we), .stop(stop), .bad_field(bad_field), .idx_ovf(idx_ovf)
    );

    function automatic logic [30:0] w(input logic s, input int b1, input int b2,
                                      input int b3, input int b4, input int b5);
        return {s, 6'(b1), 6'(b2), 6'(b3), 6'(b4), 6'(b5)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives a request, checks addressout after E0 and quiet stop after E1,
    // returns #1 after E2 where the result is visible.
    task automatic issue(input string tag, input logic [5:0] op, input logic [5:0] f,
                         input logic [11:0] a);
        @(negedge clk);
        opcode = op; field = f; addressin = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".addr"}, 32'(addressout), 32'(a));
        @(posedge clk); #1;
        check({tag, ".stop_e1"}, 32'(stop), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic expect_done(input string tag, input logic [30:0] v, input logic [2:0] rs,
                               input logic bf, input logic ov);
        check({tag, ".stop"}, 32'(stop), 32'd1);
        check({tag, ".we"}, 32'(we), 32'(!bf));
        check({tag, ".out"}, 32'(out), 32'(v));
        check({tag, ".bad"}, 32'(bad_field), 32'(bf));
        if (!bf) begin
            check({tag, ".regsel"}, 32'(regsel), 32'(rs));
            check({tag, ".ovf"}, 32'(idx_ovf), 32'(ov));
        end
    endtask

    logic [30:0] w1;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        w1 = w(1'b1, 1, 2, 3, 4, 5);
        mem[100] = w1;
        mem[101] = w(1'b0, 1, 2, 3, 4, 5);
        mem[102] = w(1'b0, 0, 0, 0, 4, 5);
        mem[200] = w(1'b0, 9, 9, 9, 9, 9);
        start = 0; opcode = 0; field = 0; addressin = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out", 32'(out), 32'd0);
        check("rst.stop", 32'(stop), 32'd0);
        check("rst.we", 32'(we), 32'd0);
        check("rst.addr", 32'(addressout), 32'd0);
        @(negedge clk); reset = 1'b0;

        issue("lda05", 6'd8, 6'd5, 12'd100);
        expect_done("lda05", w1, 3'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("lda05.stop_pulse", 32'(stop), 32'd0);
        check("lda05.we_pulse", 32'(we), 32'd0);
        check("lda05.hold", 32'(out), 32'(w1));

        issue("lda15", 6'd8, 6'd13, 12'd100);
        expect_done("lda15", w(1'b0, 1, 2, 3, 4, 5), 3'd0, 1'b0, 1'b0);
        issue("lda35", 6'd8, 6'd29, 12'd100);
        expect_done("lda35", w(1'b0, 0, 0, 3, 4, 5), 3'd0, 1'b0, 1'b0);
        issue("lda03", 6'd8, 6'd3, 12'd100);
        expect_done("lda03", w(1'b1, 0, 0, 1, 2, 3), 3'd0, 1'b0, 1'b0);
        issue("lda44", 6'd8, 6'd36, 12'd100);
        expect_done("lda44", w(1'b0, 0, 0, 0, 0, 4), 3'd0, 1'b0, 1'b0);
        issue("lda00", 6'd8, 6'd0, 12'd100);
        expect_done("lda00", w(1'b1, 0, 0, 0, 0, 0), 3'd0, 1'b0, 1'b0);
        issue("ldxn", 6'd23, 6'd13, 12'd100);
        expect_done("ldxn", w(1'b1, 1, 2, 3, 4, 5), 3'd7, 1'b0, 1'b0);

        issue("bad32", 6'd8, 6'd26, 12'd100);
        expect_done("bad32", w(1'b1, 1, 2, 3, 4, 5), 3'd0, 1'b1, 1'b0);
        issue("bad06", 6'd8, 6'd6, 12'd100);
        expect_done("bad06", w(1'b1, 1, 2, 3, 4, 5), 3'd0, 1'b1, 1'b0);
        issue("badop", 6'd5, 6'd5, 12'd100);
        expect_done("badop", w(1'b1, 1, 2, 3, 4, 5), 3'd0, 1'b1, 1'b0);

        issue("ld1ovf", 6'd9, 6'd5, 12'd101);
        expect_done("ld1ovf", w(1'b0, 1, 2, 3, 4, 5), 3'd1, 1'b0, 1'b1);
        issue("ld1ok", 6'd9, 6'd5, 12'd102);
        expect_done("ld1ok", w(1'b0, 0, 0, 0, 4, 5), 3'd1, 1'b0, 1'b0);
        issue("ld6n", 6'd22, 6'd13, 12'd102);
        expect_done("ld6n", w(1'b1, 0, 0, 0, 4, 5), 3'd6, 1'b0, 1'b0);

        // Back-to-back: new start presented while stop is high.
        issue("b2b1", 6'd8, 6'd5, 12'd101);
        expect_done("b2b1", w(1'b0, 1, 2, 3, 4, 5), 3'd0, 1'b0, 1'b0);
        opcode = 6'd8; field = 6'd5; addressin = 12'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b2.addr", 32'(addressout), 32'd100);
        @(posedge clk); #1;
        check("b2b2.stop_e1", 32'(stop), 32'd0);
        @(posedge clk); #1;
        expect_done("b2b2", w1, 3'd0, 1'b0, 1'b0);

        // start pulsed in ADDR is dropped, not queued.
        @(negedge clk);
        opcode = 6'd8; field = 6'd5; addressin = 12'd101; start = 1'b1;
        @(posedge clk); #1;
        addressin = 12'd200; field = 6'd36;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign.addr", 32'(addressout), 32'd101);
        @(posedge clk); #1;
        expect_done("ign", w(1'b0, 1, 2, 3, 4, 5), 3'd0, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            check("ign.nostop", 32'(stop), 32'd0);
        end

        // Asynchronous reset while in EXEC.
        @(negedge clk);
        opcode = 6'd8; field = 6'd5; addressin = 12'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rstx.out", 32'(out), 32'd0);
        check("rstx.addr", 32'(addressout), 32'd0);
        check("rstx.regsel", 32'(regsel), 32'd0);
        @(posedge clk); #1;
        check("rstx.stop", 32'(stop), 32'd0);
        check("rstx.we", 32'(we), 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("rstx.nostop", 32'(stop), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ld_unit.md
Name: ld_unit

Overview:
- Load execution unit for MIX opcodes 8–23 (LDA, LD1–LD6, LDX, and their negated forms LDAN…LDXN).
- Counterpart of the store unit: the store unit merges a register field into a memory word; this block reads a memory word and extracts the partial field (L:R). It right-justifies the field, applies sign rules and optional negation, and delivers the result with a register-write strobe.
- Sits between the instruction decoder, the synchronous main memory read port, and the register file.

Parameters:
- AW, 12, memory address width.
- WW, 31, word width: bit 30 = sign; five 6-bit bytes, byte1 = [29:24] … byte5 = [5:0].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- opcode  in  6  load opcode, 8..23.
- field  in  6  field spec F = 8L+R; L = field[5:3], R = field[2:0].
- addressin  in  AW  effective address.
- addressout  out  AW  memory read address, registered.
- data  in  WW  memory read data, valid the cycle after addressout is registered.
- out  out  WW  loaded value.
- regsel  out  3  destination register: 0 = A, 1..6 = I1..I6, 7 = X.
- we  out  1  register-write strobe, one cycle.
- stop  out  1  done pulse, one cycle; fires for every accepted request.
- bad_field  out  1  invalid field flag, valid with stop.
- idx_ovf  out  1  index-register overflow flag, valid with stop.

Behaviour:
- Reset (asynchronous): state = IDLE; addressout, out, regsel, we, stop, bad_field and idx_ovf all 0. Reset mid-operation aborts the operation and emits no stop.
- FSM states: IDLE → ADDR → EXEC → IDLE.
  - IDLE: on start, register addressout ← addressin, latch opcode and field, go to ADDR.
  - ADDR: memory captures the address; go to EXEC.
  - EXEC: data is valid. Compute the result; on the next edge register out, regsel, we, stop and the flags. Return to IDLE.
- Latency: start sampled at edge E0; stop/we high for exactly one cycle after edge E2.
- A new start is accepted in the cycle stop is high (stop is coincident with IDLE).
- start while in ADDR or EXEC is ignored, not queued.
- Decode:
  - regsel = (opcode − 8) mod 8.
  - negate = (opcode ≥ 16).
  - opcode outside 8..23 is treated as bad_field.
- Field validity: L ≤ R and R ≤ 5. Otherwise bad_field = 1, we = 0, stop = 1, and out keeps its previous value.
- Extraction:
  - Magnitude = bytes max(L,1)..R, right-justified; upper bytes are zero.
  - Sign = data[30] if L = 0, else 0 (positive).
  - If negate, the sign is inverted; minus-zero results are permitted.
- Index targets (regsel 1..6): idx_ovf = 1 if any of bytes 1–3 of the result magnitude is nonzero. The write still occurs with the full word; the register file truncates.
- we = stop AND NOT bad_field.
- out, regsel and flags hold their values after stop until the next completion.

Decomposition:
- Shared package (mix_pkg):
  - WW, AW, byte width 6;
  - sign bit index;
  - opcode constants OP_LDA = 8, OP_LDX = 15, OP_LDAN = 16, OP_LDXN = 23;
  - register index constants REG_A = 0, REG_X = 7;
  - FSM state enum.
- Sub-module ld_field_extract (combinational): inputs data, L, R; outputs magnitude, sign_keep, valid. It is reusable by CMPx/arith operand fetch.

Test Plan:
- Memory[100] = −|1|2|3|4|5|; LDA (0:5), opcode 8, F = 5 → after E2: out = −|1|2|3|4|5|, regsel = 0, we = 1, stop = 1 for one cycle, addressout = 100 from E0.
- Same word with F = 13 (1:5) → +|1|2|3|4|5|. F = 29 (3:5) → +|0|0|3|4|5|. F = 3 (0:3) → −|0|0|1|2|3|. F = 36 (4:4) → +|0|0|0|0|4|. F = 0 (0:0) → −|0|0|0|0|0|.
- LDXN, opcode 23, F = 13 → out = −|1|2|3|4|5|, regsel = 7.
- LDA with F = 26 (3:2) and F = 6 (0:6) → bad_field = 1, we = 0, stop = 1, out unchanged.
- LD1, opcode 9, F = 5 on +|1|2|3|4|5| → idx_ovf = 1, we = 1, regsel = 1. On +|0|0|0|4|5| → idx_ovf = 0.
- Back-to-back: start asserted in the stop cycle → second result 3 cycles later. start pulsed in ADDR → ignored. reset asserted in EXEC → all outputs 0 at once, no stop.
